// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, funct3 size
// codes, access opcodes and the bus byte-enable width.
package lsu_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } lsu_op_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads.
    function automatic logic size_legal(input lsu_op_t op, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: size_legal = 1'b1;
            F3_BU, F3_HU:     size_legal = (op == OP_LOAD);
            default:          size_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, byte enables, store-data replication
// and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic            op_store,
    input  logic [2:0]      req_size,
    input  logic [1:0]      req_addr,
    input  logic [31:0]     req_data,
    output logic            legal,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    input  logic [2:0]      ld_size,
    input  logic [1:0]      ld_addr,
    input  logic [31:0]     rdata,
    output logic [31:0]     ld_value
);

    logic        aligned;
    logic [31:0] shifted;
    lsu_op_t     op;

    assign op = op_store ? OP_STORE : OP_LOAD;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        aligned = 1'b0;
        be      = '0;
        wdata   = req_data;
        case (req_size[1:0])
            2'b00: begin
                aligned = 1'b1;
                be      = 4'b0001 << req_addr;
                wdata   = {4{req_data[7:0]}};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                be      = 4'b0011 << {req_addr[1], 1'b0};
                wdata   = {2{req_data[15:0]}};
            end
            2'b10: begin
                aligned = (req_addr == 2'b00);
                be      = 4'b1111;
            end
            default: ;
        endcase
        legal = size_legal(op, req_size) && aligned;
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign shifted = rdata >> {ld_addr, 3'b000};

    always_comb begin
        case (ld_size)
            F3_B:    ld_value = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_value = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_value = {24'd0, shifted[7:0]};
            F3_HU:   ld_value = {16'd0, shifted[15:0]};
            default: ld_value = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU memory access at a time, runs a single
// word-aligned bus transfer with ack timeout, and returns the extended load value.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk_w_i,
    input  logic            res_w_i_l,
    input  logic [31:0]     mem_addr_w_i,
    input  logic [31:0]     mem_data_w_i,
    input  logic            mem_wr_w_i_h,
    input  logic            mem_rd_w_i_h,
    input  logic [2:0]      mem_size_w_i,
    output logic [31:0]     ld_data_w_o,
    output logic            stall_w_o_h,
    output logic            misalign_w_o_h,
    output logic            err_w_o_h,
    output logic            bus_req_w_o_h,
    output logic            bus_we_w_o_h,
    output logic [31:0]     bus_addr_w_o,
    output logic [31:0]     bus_wdata_w_o,
    output logic [BE_W-1:0] bus_be_w_o,
    input  logic            bus_ack_w_i_h,
    input  logic [31:0]     bus_rdata_w_i
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    lsu_state_t      state, state_nxt;
    logic [2:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic [7:0]      cnt_q;
    logic [31:0]     ld_data_q;
    logic            err_q;

    logic            req_any, legal, accept, ack_hit, timeout;
    logic [BE_W-1:0] req_be;
    logic [31:0]     req_wdata, ld_value;

    assign req_any = mem_rd_w_i_h | mem_wr_w_i_h;

    lsu_align u_align (
        .op_store (mem_wr_w_i_h),
        .req_size (mem_size_w_i),
        .req_addr (mem_addr_w_i[1:0]),
        .req_data (mem_data_w_i),
        .legal    (legal),
        .be       (req_be),
        .wdata    (req_wdata),
        .ld_size  (size_q),
        .ld_addr  (addr_lo_q),
        .rdata    (bus_rdata_w_i),
        .ld_value (ld_value)
    );

    assign accept  = (state == ST_IDLE) && req_any && legal;
    assign ack_hit = (state == ST_BUSY) && bus_ack_w_i_h;
    // An ack in the final allowed cycle wins over the timeout.
    assign timeout = (state == ST_BUSY) && !bus_ack_w_i_h && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (ack_hit || timeout) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state         <= ST_IDLE;
            size_q        <= '0;
            addr_lo_q     <= '0;
            cnt_q         <= '0;
            ld_data_q     <= '0;
            err_q         <= 1'b0;
            bus_we_w_o_h  <= 1'b0;
            bus_addr_w_o  <= '0;
            bus_wdata_w_o <= '0;
            bus_be_w_o    <= '0;
        end else begin
            state <= state_nxt;
            err_q <= timeout;
            if (accept) begin
                size_q        <= mem_size_w_i;
                addr_lo_q     <= mem_addr_w_i[1:0];
                cnt_q         <= '0;
                bus_we_w_o_h  <= mem_wr_w_i_h;
                bus_addr_w_o  <= {mem_addr_w_i[31:2], 2'b00};
                bus_wdata_w_o <= req_wdata;
                bus_be_w_o    <= req_be;
            end else if (state == ST_BUSY && !bus_ack_w_i_h) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (!bus_we_w_o_h) begin
                if (ack_hit)      ld_data_q <= ld_value;
                else if (timeout) ld_data_q <= '0;
            end
        end
    end

    assign stall_w_o_h    = accept || (state == ST_BUSY);
    assign misalign_w_o_h = (state == ST_IDLE) && req_any && !legal;
    assign bus_req_w_o_h  = (state == ST_BUSY);
    assign err_w_o_h      = err_q;
    assign ld_data_w_o    = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset values, load extension, store lanes,
// illegal accesses, ack timeout and reset during a bus transfer.
module tb_load_store_unit;

    logic        clk_w_i = 1'b0;
    logic        res_w_i_l;
    logic [31:0] mem_addr_w_i, mem_data_w_i, bus_rdata_w_i;
    logic        mem_wr_w_i_h, mem_rd_w_i_h, bus_ack_w_i_h;
    logic [2:0]  mem_size_w_i;
    logic [31:0] ld_data_w_o, bus_addr_w_o, bus_wdata_w_o;
    logic        stall_w_o_h, misalign_w_o_h, err_w_o_h, bus_req_w_o_h, bus_we_w_o_h;
    logic [3:0]  bus_be_w_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ld;

    // Results of the most recent run_txn call.
    int          n_stall, n_req, n_misal, n_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic        s_we, s_timed_out;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk_w_i        (clk_w_i),
        .res_w_i_l      (res_w_i_l),
        .mem_addr_w_i   (mem_addr_w_i),
        .mem_data_w_i   (mem_data_w_i),
        .mem_wr_w_i_h   (mem_wr_w_i_h),
        .mem_rd_w_i_h   (mem_rd_w_i_h),
        .mem_size_w_i   (mem_size_w_i),
        .ld_data_w_o    (ld_data_w_o),
        .stall_w_o_h    (stall_w_o_h),
        .misalign_w_o_h (misalign_w_o_h),
        .err_w_o_h      (err_w_o_h),
        .bus_req_w_o_h  (bus_req_w_o_h),
        .bus_we_w_o_h   (bus_we_w_o_h),
        .bus_addr_w_o   (bus_addr_w_o),
        .bus_wdata_w_o  (bus_wdata_w_o),
        .bus_be_w_o     (bus_be_w_o),
        .bus_ack_w_i_h  (bus_ack_w_i_h),
        .bus_rdata_w_i  (bus_rdata_w_i)
    );

    always #5 clk_w_i = ~clk_w_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Presents one access and plays the bus slave; ack_after is the BUSY cycle
    // index that gets ack (-1 means never). Entered and left at posedge+1.
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] size,
                           input logic [31:0] rdata, input int ack_after);
        int busy_idx;
        n_stall = 0; n_req = 0; n_misal = 0; n_err = 0;
        s_be = '0; s_addr = '0; s_wdata = '0; s_we = 1'b0;
        s_timed_out = 1'b1;
        busy_idx = 0;
        mem_wr_w_i_h = wr; mem_rd_w_i_h = rd;
        mem_addr_w_i = addr; mem_data_w_i = data; mem_size_w_i = size;
        bus_rdata_w_i = rdata;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_w_i);
            if (stall_w_o_h)    n_stall++;
            if (misalign_w_o_h) n_misal++;
            if (err_w_o_h)      n_err++;
            bus_ack_w_i_h = 1'b0;
            if (bus_req_w_o_h) begin
                s_be = bus_be_w_o; s_addr = bus_addr_w_o;
                s_wdata = bus_wdata_w_o; s_we = bus_we_w_o_h;
                if (busy_idx == ack_after) bus_ack_w_i_h = 1'b1;
                busy_idx++;
                n_req++;
            end
            if (!stall_w_o_h) begin
                @(posedge clk_w_i); #1;
                s_timed_out = 1'b0;
                break;
            end
        end
        if (s_timed_out) begin
            @(posedge clk_w_i); #1;
        end
        mem_wr_w_i_h = 1'b0; mem_rd_w_i_h = 1'b0; bus_ack_w_i_h = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_w_i);
        checks++; if (bus_req_w_o_h !== 1'b0) begin failures++; $display("FAIL rst_req got %b want 0", bus_req_w_o_h); end
        checks++; if (bus_we_w_o_h !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", bus_we_w_o_h); end
        checks++; if (bus_be_w_o !== 4'b0000) begin failures++; $display("FAIL rst_be got %b want 0000", bus_be_w_o); end
        checks++; if (bus_addr_w_o !== 32'h0) begin failures++; $display("FAIL rst_addr got %h want 0", bus_addr_w_o); end
        checks++; if (bus_wdata_w_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got %h want 0", bus_wdata_w_o); end
        checks++; if (ld_data_w_o !== 32'h0) begin failures++; $display("FAIL rst_ld got %h want 0", ld_data_w_o); end
        checks++; if ({err_w_o_h, misalign_w_o_h, stall_w_o_h} !== 3'b000) begin
            failures++; $display("FAIL rst_flags got %b want 000", {err_w_o_h, misalign_w_o_h, stall_w_o_h});
        end
        @(posedge clk_w_i); #1;
        res_w_i_l = 1'b1;
        exp_ld = 32'h0;
    endtask

    task automatic test_lw();
        run_txn(1'b0, 1'b1, 32'h1004, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        exp_ld = 32'hDEADBEEF;
        checks++; if (s_timed_out !== 1'b0) begin failures++; $display("FAIL lw_done got timeout want completion"); end
        checks++; if (s_be !== 4'b1111) begin failures++; $display("FAIL lw_be got %b want 1111", s_be); end
        checks++; if (s_addr !== 32'h1004) begin failures++; $display("FAIL lw_addr got %h want 00001004", s_addr); end
        checks++; if (s_we !== 1'b0) begin failures++; $display("FAIL lw_we got %b want 0", s_we); end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL lw_data got %h want %h", ld_data_w_o, exp_ld); end
        checks++; if (n_stall != 2) begin failures++; $display("FAIL lw_stall got %0d want 2", n_stall); end
        checks++; if (n_req != 1) begin failures++; $display("FAIL lw_req got %0d want 1", n_req); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  sz [5];
        logic [31:0] ad [5];
        logic [3:0]  be [5];
        logic [31:0] ex [5];
        sz[0] = 3'b000; ad[0] = 32'h1003; be[0] = 4'b1000; ex[0] = 32'hFFFFFF80;
        sz[1] = 3'b100; ad[1] = 32'h1003; be[1] = 4'b1000; ex[1] = 32'h00000080;
        sz[2] = 3'b101; ad[2] = 32'h1002; be[2] = 4'b1100; ex[2] = 32'h00008012;
        sz[3] = 3'b001; ad[3] = 32'h1002; be[3] = 4'b1100; ex[3] = 32'hFFFF8012;
        sz[4] = 3'b100; ad[4] = 32'h1001; be[4] = 4'b0010; ex[4] = 32'h00000034;
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b0, 1'b1, ad[i], 32'h0, sz[i], 32'h80123456, 0);
            exp_ld = ex[i];
            checks++; if (s_be !== be[i]) begin failures++; $display("FAIL ld%0d_be got %b want %b", i, s_be, be[i]); end
            checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL ld%0d_data got %h want %h", i, ld_data_w_o, exp_ld); end
            checks++; if (s_addr !== 32'h1000) begin failures++; $display("FAIL ld%0d_addr got %h want 00001000", i, s_addr); end
        end
    endtask

    task automatic test_store();
        run_txn(1'b1, 1'b0, 32'h2002, 32'h0000ABCD, 3'b001, 32'h0, 0);
        checks++; if (s_we !== 1'b1) begin failures++; $display("FAIL sh_we got %b want 1", s_we); end
        checks++; if (s_be !== 4'b1100) begin failures++; $display("FAIL sh_be got %b want 1100", s_be); end
        checks++; if (s_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got %h want abcdabcd", s_wdata); end
        checks++; if (s_addr !== 32'h2000) begin failures++; $display("FAIL sh_addr got %h want 00002000", s_addr); end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL sh_ld_hold got %h want %h", ld_data_w_o, exp_ld); end
        run_txn(1'b1, 1'b0, 32'h3001, 32'h12345678, 3'b000, 32'h0, 0);
        checks++; if (s_be !== 4'b0010) begin failures++; $display("FAIL sb_be got %b want 0010", s_be); end
        checks++; if (s_wdata !== 32'h78787878) begin failures++; $display("FAIL sb_wdata got %h want 78787878", s_wdata); end
        run_txn(1'b1, 1'b0, 32'h4000, 32'hCAFEF00D, 3'b010, 32'h0, 0);
        checks++; if ({s_we, s_be} !== 5'b11111) begin failures++; $display("FAIL sw_we_be got %b want 11111", {s_we, s_be}); end
        checks++; if (s_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_wdata got %h want cafef00d", s_wdata); end
        run_txn(1'b1, 1'b1, 32'h5000, 32'h11223344, 3'b010, 32'h0, 0);
        checks++; if (s_we !== 1'b1) begin failures++; $display("FAIL prio_we got %b want 1", s_we); end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL prio_ld_hold got %h want %h", ld_data_w_o, exp_ld); end
    endtask

    task automatic test_misalign();
        logic        wr [4];
        logic [31:0] ad [4];
        logic [2:0]  sz [4];
        wr[0] = 1'b0; ad[0] = 32'h1001; sz[0] = 3'b010;
        wr[1] = 1'b0; ad[1] = 32'h1000; sz[1] = 3'b011;
        wr[2] = 1'b0; ad[2] = 32'h1003; sz[2] = 3'b001;
        wr[3] = 1'b1; ad[3] = 32'h1000; sz[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            run_txn(wr[i], ~wr[i], ad[i], 32'h0, sz[i], 32'h0, 0);
            checks++; if (n_misal != 1) begin failures++; $display("FAIL mis%0d_pulse got %0d want 1", i, n_misal); end
            checks++; if (n_req != 0 || n_stall != 0) begin
                failures++; $display("FAIL mis%0d_nobus got req=%0d stall=%0d want 0/0", i, n_req, n_stall);
            end
            @(negedge clk_w_i);
            checks++; if ({misalign_w_o_h, bus_req_w_o_h} !== 2'b00) begin
                failures++; $display("FAIL mis%0d_after got %b want 00", i, {misalign_w_o_h, bus_req_w_o_h});
            end
            checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL mis%0d_ld_hold got %h want %h", i, ld_data_w_o, exp_ld); end
            @(posedge clk_w_i); #1;
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 32'h6000, 32'h0, 3'b010, 32'h12121212, -1);
        exp_ld = 32'h0;
        checks++; if (n_req != 4) begin failures++; $display("FAIL to_req got %0d want 4", n_req); end
        checks++; if (n_err != 1) begin failures++; $display("FAIL to_err got %0d want 1", n_err); end
        checks++; if (n_stall != 5) begin failures++; $display("FAIL to_stall got %0d want 5", n_stall); end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL to_ld got %h want 0", ld_data_w_o); end
        @(negedge clk_w_i);
        checks++; if ({err_w_o_h, bus_req_w_o_h, stall_w_o_h} !== 3'b000) begin
            failures++; $display("FAIL to_idle got %b want 000", {err_w_o_h, bus_req_w_o_h, stall_w_o_h});
        end
        @(posedge clk_w_i); #1;
        run_txn(1'b0, 1'b1, 32'h6004, 32'h0, 3'b010, 32'h0BADF00D, 3);
        exp_ld = 32'h0BADF00D;
        checks++; if (n_req != 4 || n_err != 0) begin
            failures++; $display("FAIL late_ack got req=%0d err=%0d want 4/0", n_req, n_err);
        end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL late_ack_ld got %h want %h", ld_data_w_o, exp_ld); end
    endtask

    task automatic test_reset_mid();
        mem_rd_w_i_h = 1'b1; mem_addr_w_i = 32'h7000; mem_size_w_i = 3'b010;
        bus_rdata_w_i = 32'h55AA55AA;
        @(posedge clk_w_i); #1;
        mem_rd_w_i_h = 1'b0;
        @(negedge clk_w_i);
        checks++; if (bus_req_w_o_h !== 1'b1) begin failures++; $display("FAIL rm_busy got %b want 1", bus_req_w_o_h); end
        #1 res_w_i_l = 1'b0;
        #1;
        exp_ld = 32'h0;
        checks++; if ({bus_req_w_o_h, stall_w_o_h, err_w_o_h} !== 3'b000) begin
            failures++; $display("FAIL rm_abort got %b want 000", {bus_req_w_o_h, stall_w_o_h, err_w_o_h});
        end
        checks++; if (ld_data_w_o !== exp_ld) begin failures++; $display("FAIL rm_ld got %h want 0", ld_data_w_o); end
        @(posedge clk_w_i); #1;
        res_w_i_l = 1'b1;
        bus_ack_w_i_h = 1'b1;
        @(posedge clk_w_i); #1;
        bus_ack_w_i_h = 1'b0;
        @(negedge clk_w_i);
        checks++; if ({bus_req_w_o_h, err_w_o_h, ld_data_w_o} !== {2'b00, exp_ld}) begin
            failures++; $display("FAIL rm_stray_ack got req=%b err=%b ld=%h want 0/0/0", bus_req_w_o_h, err_w_o_h, ld_data_w_o);
        end
        @(posedge clk_w_i); #1;
        run_txn(1'b0, 1'b1, 32'h7004, 32'h0, 3'b010, 32'h13579BDF, 0);
        exp_ld = 32'h13579BDF;
        checks++; if (ld_data_w_o !== exp_ld || n_stall != 2) begin
            failures++; $display("FAIL rm_next got ld=%h stall=%0d want %h/2", ld_data_w_o, n_stall, exp_ld);
        end
    endtask

    initial begin
        res_w_i_l = 1'b0;
        mem_addr_w_i = '0; mem_data_w_i = '0; mem_size_w_i = '0;
        mem_wr_w_i_h = 1'b0; mem_rd_w_i_h = 1'b0;
        bus_ack_w_i_h = 1'b0; bus_rdata_w_i = '0;
        exp_ld = '0;
        repeat (2) @(posedge clk_w_i);
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, bus cycles waited for bus_ack_w_i_h before abort; legal range 1..255.
REQ-002 Ports: clk_w_i  in  1  sole clock, rising edge; res_w_i_l  in  1  reset, asynchronous, active-low.
REQ-003 CPU side: mem_addr_w_i  in  32  byte address (ALU result); mem_data_w_i  in  32  store data (rs2); mem_wr_w_i_h  in  1  store request; mem_rd_w_i_h  in  1  load request; mem_size_w_i  in  3  funct3 size/sign code.
REQ-004 CPU side: ld_data_w_o  out  32  aligned, extended load result; stall_w_o_h  out  1  hold PC/instruction; misalign_w_o_h  out  1  one-cycle illegal-access pulse; err_w_o_h  out  1  one-cycle timeout pulse.
REQ-005 Bus side: bus_req_w_o_h  out  1; bus_we_w_o_h  out  1; bus_addr_w_o  out  32  word aligned, [1:0]=00; bus_wdata_w_o  out  32; bus_be_w_o  out  4  byte enables; bus_ack_w_i_h  in  1; bus_rdata_w_i  in  32.

Function
REQ-006 FSM states IDLE, BUSY, DONE; only IDLE accepts requests.
REQ-007 Accept in IDLE when (rd|wr) and access legal; wr has priority if both asserted; request fields registered on that edge, next state BUSY.
REQ-008 stall_w_o_h = (IDLE & (rd|wr) & legal) | BUSY, combinational; low in DONE.
REQ-009 BUSY: bus_req_w_o_h high, bus outputs held stable from registered request; on bus_ack_w_i_h capture bus_rdata_w_i, next DONE.
REQ-010 DONE lasts exactly one cycle, unconditionally returns to IDLE; request inputs ignored in DONE (same instruction still presented).
REQ-011 Minimum latency, ack in first BUSY cycle: 3 cycles accept-to-IDLE, stall high 2 cycles.
REQ-012 Legal sizes: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; all other codes illegal.
REQ-013 Misaligned: half with addr[0]=1, word with addr[1:0]!=00; illegal or misaligned -> misalign_w_o_h high that cycle, no bus cycle, no stall, ld_data_w_o unchanged.
REQ-014 Byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; loads drive the same enables.
REQ-015 Store data lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-016 Load: select lane from captured word by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU); ld_data_w_o registered, updates only on load completion, holds otherwise.
REQ-017 Timeout counter 8 bits, cleared on accept, increments each BUSY cycle without ack; at ACK_TIMEOUT: drop bus_req, pulse err_w_o_h, load result 0, go DONE.
REQ-018 bus_ack_w_i_h outside BUSY ignored; ack coinciding with timeout is treated as success.

Reset
REQ-019 res_w_i_l low asynchronously forces IDLE, bus_req_w_o_h=0, bus_we_w_o_h=0, bus_be_w_o=0000, bus_addr_w_o=0, bus_wdata_w_o=0, ld_data_w_o=0, err/misalign=0, counter=0.
REQ-020 Reset mid-transaction abandons it without err pulse; first accept possible in the cycle after deassertion.

Structure
REQ-021 Shared package holds FSM state encoding, funct3 size codes, load/store opcodes, bus_be width constant.
REQ-022 One combinational sub-module lsu_align: legality check, byte enables, store lane replication, load extraction/extension.

Verification
REQ-023 LW addr 0x1004, rdata 0xDEADBEEF, ack in first BUSY -> be 1111, addr 0x1004, ld_data 0xDEADBEEF, stall 2 cycles.
REQ-024 LB addr 0x1003, rdata 0x80123456 -> be 1000, ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x1002 -> 0x00008012.
REQ-025 SH addr 0x2002, data 0x0000ABCD -> bus_we 1, be 1100, wdata 0xABCDABCD, bus_addr 0x2000.
REQ-026 LW addr 0x1001 and funct3 011 -> misalign pulse 1 cycle, bus_req never high, stall 0.
REQ-027 ACK_TIMEOUT=4, no ack -> bus_req high 4 cycles, err pulse, ld_data 0, back to IDLE.
REQ-028 res_w_i_l low mid-BUSY -> bus_req 0 immediately, state IDLE, late ack ignored, next LW completes normally.
